// File: rtl/aucohl_fifo_wr_arb.sv
// rtl/aucohl_fifo_wr_arb.sv - round-robin burst arbiter sharing one fifo write port among N requesters
module aucohl_fifo_wr_arb #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    input  logic            fifo_full,
    output logic            fifo_wr,
    output logic [DW-1:0]   fifo_wdata,
    output logic [N-1:0]    grant,
    output logic            busy
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q;
    logic [N-1:0]   grant_q;
    logic [LW-1:0]  last_q;
    logic [CW-1:0]  burst_cnt_q;

    logic           sel_found;
    logic [LW-1:0]  sel_idx;
    logic           own_valid;
    logic           xfer;
    logic           burst_done;

    // Walk downward so the requester closest after last_q is the one kept.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_valid[(int'(last_q) + k) % N]) begin
                sel_found = 1'b1;
                sel_idx   = LW'((int'(last_q) + k) % N);
            end
        end
    end

    // While granted, last_q doubles as the owner index.
    assign own_valid  = req_valid[last_q];
    assign xfer       = (|grant_q) & own_valid & ~fifo_full;
    assign burst_done = (burst_cnt_q == CW'(MAX_BURST - 1));

    assign req_ready  = fifo_full ? '0 : grant_q;
    assign fifo_wr    = xfer;
    assign fifo_wdata = (|grant_q) ? req_data[int'(last_q)*DW +: DW] : '0;
    assign grant      = grant_q;
    assign busy       = |grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= LW'(N - 1);
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        grant_q     <= {{(N-1){1'b0}}, 1'b1} << sel_idx;
                        last_q      <= sel_idx;
                        burst_cnt_q <= '0;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!own_valid) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else if (xfer) begin
                        burst_cnt_q <= burst_cnt_q + CW'(1);
                        if (burst_done) begin
                            grant_q <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aucohl_fifo_wr_arb.sv
// tb/tb_aucohl_fifo_wr_arb.sv - scoreboard bench for aucohl_fifo_wr_arb (N=4/MAX_BURST=4 and N=2/MAX_BURST=1)
module tb_aucohl_fifo_wr_arb;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid0;
    logic [31:0] req_data0;
    logic [3:0]  req_ready0;
    logic        fifo_full0;
    logic        fifo_wr0;
    logic [7:0]  fifo_wdata0;
    logic [3:0]  grant0;
    logic        busy0;
    logic [1:0]  req_valid1;
    logic [15:0] req_data1;
    logic [1:0]  req_ready1;
    logic        fifo_full1;
    logic        fifo_wr1;
    logic [7:0]  fifo_wdata1;
    logic [1:0]  grant1;
    logic        busy1;

    aucohl_fifo_wr_arb #(.N(4), .DW(8), .MAX_BURST(4)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .fifo_full(fifo_full0), .fifo_wr(fifo_wr0),
        .fifo_wdata(fifo_wdata0), .grant(grant0), .busy(busy0)
    );

    aucohl_fifo_wr_arb #(.N(2), .DW(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_data(req_data1),
        .req_ready(req_ready1), .fifo_full(fifo_full1), .fifo_wr(fifo_wr1),
        .fifo_wdata(fifo_wdata1), .grant(grant1), .busy(busy1)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] ready;
        logic       wr;
        logic [7:0] wd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   m_owner[2];
    int   m_cnt[2];
    int   m_last[2];
    int   tests  = 0;
    int   failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner[0] = -1; m_cnt[0] = 0; m_last[0] = 3;
        m_owner[1] = -1; m_cnt[1] = 0; m_last[1] = 1;
    endtask

    // Expected outputs for this cycle from current owner, then the owner for the next cycle.
    task automatic model_step(input int id, input logic [3:0] v, input logic fl,
                              input logic [31:0] d, output exp_t e);
        int n;
        int mb;
        int o;
        bit found;
        n  = (id == 0) ? 4 : 2;
        mb = (id == 0) ? 4 : 1;
        o  = m_owner[id];
        e  = '0;
        if (o >= 0) begin
            e.grant = 4'(1 << o);
            e.ready = fl ? 4'd0 : e.grant;
            e.wr    = v[o] & ~fl;
            e.wd    = d[o*8 +: 8];
        end
        if (o < 0) begin
            found = 0;
            for (int k = 1; k <= n; k++) begin
                if (!found && v[(m_last[id] + k) % n]) begin
                    found       = 1;
                    m_owner[id] = (m_last[id] + k) % n;
                    m_last[id]  = m_owner[id];
                    m_cnt[id]   = 0;
                end
            end
        end else if (!v[o]) begin
            m_owner[id] = -1;
        end else if (e.wr) begin
            m_cnt[id]++;
            if (m_cnt[id] == mb) m_owner[id] = -1;
        end
    endtask

    task automatic cyc(input logic [3:0] v0, input logic f0, input logic [1:0] v1, input logic f1);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid0 = v0;
        fifo_full0 = f0;
        req_data0  = $urandom;
        req_valid1 = v1;
        fifo_full1 = f1;
        req_data1  = 16'($urandom);
        model_step(0, v0, f0, req_data0, e);
        q0.push_back(e);
        model_step(1, {2'b00, v1}, f1, {16'd0, req_data1}, e);
        q1.push_back(e);
    endtask

    // Called at posedge+1: asserts reset mid-cycle and checks outputs drop at once.
    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_grant0", {28'd0, grant0}, 0);
        chk("rst_wr0", {31'd0, fifo_wr0}, 0);
        chk("rst_ready0", {28'd0, req_ready0}, 0);
        chk("rst_wdata0", {24'd0, fifo_wdata0}, 0);
        chk("rst_busy0", {31'd0, busy0}, 0);
        chk("rst_grant1", {30'd0, grant1}, 0);
        chk("rst_wr1", {31'd0, fifo_wr1}, 0);
        req_valid0 = '0;
        req_valid1 = '0;
        fifo_full0 = 1'b0;
        fifo_full1 = 1'b0;
        q0.delete();
        q1.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("grant0", {28'd0, grant0}, {28'd0, e.grant});
                chk("ready0", {28'd0, req_ready0}, {28'd0, e.ready});
                chk("wr0", {31'd0, fifo_wr0}, {31'd0, e.wr});
                chk("busy0", {31'd0, busy0}, {31'd0, |e.grant});
                if (e.grant != 0) chk("wdata0", {24'd0, fifo_wdata0}, {24'd0, e.wd});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("grant1", {30'd0, grant1}, {28'd0, e.grant});
                chk("ready1", {30'd0, req_ready1}, {28'd0, e.ready});
                chk("wr1", {31'd0, fifo_wr1}, {31'd0, e.wr});
                if (e.grant != 0) chk("wdata1", {24'd0, fifo_wdata1}, {24'd0, e.wd});
            end
        end
    end

    initial begin
        rst        = 1'b1;
        req_valid0 = '0;
        req_data0  = '0;
        fifo_full0 = 1'b0;
        req_valid1 = '0;
        req_data1  = '0;
        fifo_full1 = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_pulse();

        // single requester, three words; second instance alternates with MAX_BURST=1
        repeat (4) cyc(4'b0001, 1'b0, 2'b11, 1'b0);
        repeat (3) cyc(4'b0000, 1'b0, 2'b11, 1'b0);
        // full contention
        repeat (24) cyc(4'b1111, 1'b0, 2'b11, 1'b0);
        // backpressure mid-burst
        repeat (2) cyc(4'b1111, 1'b0, 2'b11, 1'b0);
        repeat (5) cyc(4'b1111, 1'b1, 2'b11, 1'b1);
        repeat (8) cyc(4'b1111, 1'b0, 2'b11, 1'b0);
        // early release of owner 2 while 3 waits
        cyc(4'b0000, 1'b0, 2'b00, 1'b0);
        #0 reset_pulse();
        cyc(4'b0100, 1'b0, 2'b11, 1'b0);
        cyc(4'b1100, 1'b0, 2'b11, 1'b0);
        cyc(4'b1100, 1'b0, 2'b11, 1'b0);
        repeat (3) cyc(4'b1000, 1'b0, 2'b11, 1'b0);
        cyc(4'b0000, 1'b0, 2'b00, 1'b0);
        // reset during owner 1's second word
        reset_pulse();
        repeat (3) cyc(4'b0010, 1'b0, 2'b10, 1'b0);
        reset_pulse();
        repeat (6) cyc(4'b1111, 1'b0, 2'b11, 1'b0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(4'($urandom) | 4'($urandom), ($urandom_range(0, 3) == 0),
                2'($urandom) | 2'($urandom), ($urandom_range(0, 3) == 0));
        end
        @(negedge clk);
        #1;
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
